sha256_msched: RTL

SHA256_MSCHED -- requirements
Module: sha256_msched

---
 rtl/sha256_msched_if.sv | 25 ++
 rtl/sha256_msched.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sha256_msched_if.sv
// Handshake bundle between the message loader, the schedule expander and the
// round stage. The master side feeds message words and consumes schedule
// words; the slave side is the expander itself.
interface sha256_msched_if;
    logic        start;
    logic        in_valid;
    logic [31:0] in_word;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        busy;

    modport master (
        output start, in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word, out_idx, out_last, busy
    );

    modport slave (
        input  start, in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word, out_idx, out_last, busy
    );
endinterface

// File: rtl/sha256_msched.sv
// SHA-256 message schedule generator. Accepts the 16 message words of a
// block, passes them straight through as W[0..15], then expands W[16..]
// from a 16-entry circular window. Output is a single register with a
// valid/ready handshake, so back-pressure freezes the whole pipeline.
// ROUNDS must lie in 17..64 so that at least one expanded word exists.
module sha256_msched #(
    parameter int ROUNDS = 64
) (
    input  logic           clk,
    input  logic           rst,
    sha256_msched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        DRAIN
    } state_t;

    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);
    localparam logic [6:0] LOAD_LAST_T = 7'd15;

    state_t      r_state;
    state_t      w_nextState;
    logic [6:0]  r_t;
    logic [31:0] r_win [16];
    logic [31:0] r_outWord;
    logic [5:0]  r_outIdx;
    logic        r_outValid;
    logic        r_outLast;

    logic        w_free;
    logic        w_loadXfer;
    logic        w_expStep;
    logic        w_advance;
    logic        w_inReady;
    logic        w_busy;
    logic [3:0]  w_slot;
    logic [3:0]  w_slotM2;
    logic [3:0]  w_slotM7;
    logic [3:0]  w_slotM15;
    logic [31:0] w_newWord;
    logic [31:0] w_nextWord;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // The output register can take a new word when it is empty or being
    // drained this cycle; every advance of the block is gated by this.
    always_comb begin
        w_free     = !r_outValid || bus.out_ready;
        w_loadXfer = (r_state == LOAD) && w_free && bus.in_valid;
        w_expStep  = (r_state == EXPAND) && w_free;
        w_advance  = w_loadXfer || w_expStep;
    end

    // Window read addresses for W[t-2], W[t-7], W[t-15] and W[t-16]; the
    // 4-bit wrap does the modulo-16, and slot t&15 is both the oldest word
    // read and the slot the new word overwrites.
    always_comb begin
        w_slot     = r_t[3:0];
        w_slotM2   = w_slot + 4'd14;
        w_slotM7   = w_slot + 4'd9;
        w_slotM15  = w_slot + 4'd1;
        w_newWord  = sig1(r_win[w_slotM2]) + r_win[w_slotM7]
                   + sig0(r_win[w_slotM15]) + r_win[w_slot];
        w_nextWord = (r_state == LOAD) ? bus.in_word : w_newWord;
    end

    // State register for the block sequencer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: load 16 words, expand up to the last round, then
    // wait for the consumer to take the final word before going idle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                if (w_loadXfer && (r_t == LOAD_LAST_T)) begin
                    w_nextState = EXPAND;
                end
            end
            EXPAND: begin
                if (w_expStep && (r_t == LAST_T)) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (r_outValid && bus.out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State-derived handshake outputs.
    always_comb begin
        w_inReady = (r_state == LOAD) && w_free;
        w_busy    = (r_state != IDLE);
    end

    // Window storage is deliberately left unreset: every slot is rewritten
    // during LOAD before anything reads it.
    always_ff @(posedge clk) begin
        if (rst && w_advance) begin
            r_win[w_slot] <= w_nextWord;
        end
    end

    // Word counter and output register: each advance loads the next word
    // and its index; a consumed word with nothing behind it empties the
    // register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_t        <= '0;
            r_outWord  <= '0;
            r_outIdx   <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
        end else begin
            if ((r_state == IDLE) && bus.start) begin
                r_t <= '0;
            end
            if (w_advance) begin
                r_outWord  <= w_nextWord;
                r_outIdx   <= r_t[5:0];
                r_outValid <= 1'b1;
                r_outLast  <= (r_t == LAST_T);
                r_t        <= r_t + 7'd1;
            end else if (r_outValid && bus.out_ready) begin
                r_outValid <= 1'b0;
                r_outLast  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.busy      = w_busy;
    assign bus.out_valid = r_outValid;
    assign bus.out_word  = r_outWord;
    assign bus.out_idx   = r_outIdx;
    assign bus.out_last  = r_outLast;

endmodule
